// File: rtl/ps2_cmd_sender_if.sv
// Command request channel into the PS/2 command sender.
// A command transfers on a rising clk edge when cmd_valid && cmd_ready. Once the command is accepted,
// cmd_sel/cmd_val are don't-care, and cmd_ready stays low until the whole sequence has been sent.
interface ps2_cmd_sender_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_sel;
  logic [2:0] cmd_val;

  modport master (output cmd_valid, cmd_sel, cmd_val, input cmd_ready);
  modport slave  (input cmd_valid, cmd_sel, cmd_val, output cmd_ready);
endinterface

// File: rtl/ps2_cmd_sender.sv
// Device-side PS/2 keyboard emulator: expands one command into its scancode sequence and
// shifts each byte out as an 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop).
module ps2_cmd_sender #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP        = 5000,
  parameter int SEND_BREAK = 0
) (
  input  logic              clk,
  input  logic              reset,
  ps2_cmd_sender_if.slave   cmd,
  output logic              ps2_clk,
  output logic              ps2_data,
  output logic              busy,
  output logic              byte_done,
  output logic [1:0]        state_dbg
);

  localparam int HW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      val_q, val_d;
  logic [3:0]      idx_q, idx_d;
  logic [10:0]     shreg_q, shreg_d;
  logic [3:0]      bit_q, bit_d;
  logic [HW-1:0]   half_q, half_d;
  logic            phase_q, phase_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            clk_q, clk_d;
  logic            data_q, data_d;
  logic            done_q, done_d;

  logic            ready;
  logic [1:0]      key_num;
  logic            is_brk;
  logic [3:0]      last_idx;
  logic [7:0]      lvl_code, key_code, cur_byte;

  // Byte at the current index. With break codes each key occupies three slots: K, F0, K.
  always_comb begin
    key_num  = 2'd0;
    is_brk   = 1'b0;
    last_idx = 4'd0;
    if (SEND_BREAK != 0) begin
      case (idx_q)
        4'd0, 4'd1, 4'd2: key_num = 2'd0;
        4'd3, 4'd4, 4'd5: key_num = 2'd1;
        default:          key_num = 2'd2;
      endcase
      is_brk   = (idx_q == 4'd1) || (idx_q == 4'd4) || (idx_q == 4'd7);
      last_idx = (sel_q == 2'b10) ? 4'd2 : 4'd8;
    end else begin
      key_num  = idx_q[1:0];
      last_idx = (sel_q == 2'b10) ? 4'd0 : 4'd2;
    end

    case (val_q)
      3'd0:    lvl_code = 8'h16;
      3'd1:    lvl_code = 8'h1E;
      3'd2:    lvl_code = 8'h26;
      3'd3:    lvl_code = 8'h25;
      3'd4:    lvl_code = 8'h2E;
      3'd5:    lvl_code = 8'h36;
      3'd6:    lvl_code = 8'h3D;
      default: lvl_code = 8'h3E;
    endcase

    case (key_num)
      2'd0:    key_code = (sel_q == 2'b10) ? 8'h24 : 8'h5A;
      2'd1:    key_code = (sel_q == 2'b00) ? lvl_code : (val_q[0] ? 8'h33 : 8'h31);
      default: key_code = 8'h24;
    endcase

    cur_byte = is_brk ? 8'hF0 : key_code;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    val_d   = val_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    half_d  = half_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    clk_d   = clk_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && (cmd.cmd_sel != 2'b11)) begin
          sel_d   = cmd.cmd_sel;
          val_d   = cmd.cmd_val;
          idx_d   = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = {1'b1, ~^cur_byte, cur_byte, 1'b0};
        bit_d   = 4'd0;
        half_d  = '0;
        phase_d = 1'b0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Data changes only at the start of a slot, so it is stable across the falling edge.
        if (!phase_q && (half_q == '0)) begin
          data_d  = shreg_q[0];
          shreg_d = {1'b1, shreg_q[10:1]};
        end
        clk_d = ~phase_q;
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == 4'd10) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      default: begin
        if (gap_q == '0) begin
          clk_d  = 1'b1;
          data_d = 1'b1;
          done_d = 1'b1;
        end
        if (gap_q == GAP_LAST) begin
          if (idx_q == last_idx) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      val_q   <= 3'd0;
      idx_q   <= 4'd0;
      shreg_q <= '1;
      bit_q   <= 4'd0;
      half_q  <= '0;
      phase_q <= 1'b0;
      gap_q   <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign ready         = (state_q == S_IDLE);
  assign cmd.cmd_ready = ready;
  assign busy          = ~ready;
  assign ps2_clk       = clk_q;
  assign ps2_data      = data_q;
  assign byte_done     = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ps2_cmd_sender.sv
// Bench for ps2_cmd_sender: two instances (make-only and make+break), bytes decoded on ps2_clk falls
// and compared against hand-computed scancode tables.
module tb_ps2_cmd_sender;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_cmd_sender_if nb_if();
  ps2_cmd_sender_if br_if();

  logic nb_ps2_clk, nb_ps2_data, nb_busy, nb_done;
  logic br_ps2_clk, br_ps2_data, br_busy, br_done;
  logic [1:0] nb_state, br_state;

  ps2_cmd_sender #(.CLK_DIV(CLK_DIV), .GAP(GAP), .SEND_BREAK(0)) u_nb (
    .clk(clk), .reset(reset), .cmd(nb_if.slave),
    .ps2_clk(nb_ps2_clk), .ps2_data(nb_ps2_data), .busy(nb_busy),
    .byte_done(nb_done), .state_dbg(nb_state));

  ps2_cmd_sender #(.CLK_DIV(CLK_DIV), .GAP(GAP), .SEND_BREAK(1)) u_br (
    .clk(clk), .reset(reset), .cmd(br_if.slave),
    .ps2_clk(br_ps2_clk), .ps2_data(br_ps2_data), .busy(br_busy),
    .byte_done(br_done), .state_dbg(br_state));

  logic use_br = 1'b0;
  logic m_clk, m_data, m_busy, m_done, m_ready;
  assign m_clk   = use_br ? br_ps2_clk  : nb_ps2_clk;
  assign m_data  = use_br ? br_ps2_data : nb_ps2_data;
  assign m_busy  = use_br ? br_busy     : nb_busy;
  assign m_done  = use_br ? br_done     : nb_done;
  assign m_ready = use_br ? br_if.cmd_ready : nb_if.cmd_ready;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  got_b[9];
  logic [10:0] frame_b[9];
  int          done_t[9];
  int          n_got, n_done, n_ferr;
  logic        timed_out;

  typedef struct {
    logic        br;
    logic [1:0]  sel;
    logic [2:0]  val;
    int          n;
    logic [71:0] bytes;  // first byte in the top 8 bits
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic br, input logic v, input logic [1:0] s, input logic [2:0] val);
    if (br) begin
      br_if.cmd_valid = v; br_if.cmd_sel = s; br_if.cmd_val = val;
    end else begin
      nb_if.cmd_valid = v; nb_if.cmd_sel = s; nb_if.cmd_val = val;
    end
  endtask

  // Decode frames on the selected instance until it is ready again.
  task automatic wait_done(input int budget);
    logic       prev_clk;
    logic [10:0] cur;
    int         bcnt;
    int         cyc;
    prev_clk = 1'b1; cur = '0; bcnt = 0;
    n_got = 0; n_done = 0; n_ferr = 0; timed_out = 1'b1;
    for (int i = 0; i < 9; i++) begin
      got_b[i] = '0; frame_b[i] = '0; done_t[i] = 0;
    end
    for (cyc = 0; cyc < budget; cyc++) begin
      if (prev_clk && !m_clk) begin
        cur[bcnt] = m_data;
        bcnt++;
        if (bcnt == 11) begin
          if (cur[0] !== 1'b0 || cur[10] !== 1'b1 || cur[9] !== ~^cur[8:1]) n_ferr++;
          if (n_got < 9) begin
            got_b[n_got]   = cur[8:1];
            frame_b[n_got] = cur;
          end
          n_got++;
          bcnt = 0;
        end
      end
      prev_clk = m_clk;
      if (m_done) begin
        if (n_done < 9) done_t[n_done] = cyc;
        n_done++;
      end
      if (m_ready && cyc > 0) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (bcnt != 0) n_ferr++;
  endtask

  task automatic run_cmd(input logic br, input logic [1:0] s, input logic [2:0] v);
    use_br = br;
    @(negedge clk);
    drive(br, 1'b1, s, v);
    @(negedge clk);
    drive(br, 1'b0, s, v);
    wait_done(3000);
  endtask

  // ---------------- test sequence ----------------
  int exp_5a[11] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};

  initial begin
    int  viol, lat, rc, dn, falls;
    logic hit, pc;

    vecs[0] = '{1'b0, 2'b00, 3'd3, 3, 72'h5A2524_000000000000};
    vecs[1] = '{1'b1, 2'b01, 3'd1, 9, 72'h5AF05A33F03324F024};
    vecs[2] = '{1'b0, 2'b01, 3'd0, 3, 72'h5A3124_000000000000};
    vecs[3] = '{1'b0, 2'b10, 3'd5, 1, 72'h24_0000000000000000};
    vecs[4] = '{1'b0, 2'b00, 3'd7, 3, 72'h5A3E24_000000000000};
    vecs[5] = '{1'b1, 2'b10, 3'd0, 3, 72'h24F024_000000000000};
    vecs[6] = '{1'b0, 2'b00, 3'd0, 3, 72'h5A1624_000000000000};
    vecs[7] = '{1'b1, 2'b00, 3'd5, 9, 72'h5AF05A36F03624F024};

    drive(1'b0, 1'b0, 2'b00, 3'd0);
    drive(1'b1, 1'b0, 2'b00, 3'd0);
    repeat (3) @(negedge clk);

    // Reset state on both instances
    check("rst_nb_clk",   32'(nb_ps2_clk), 32'd1);
    check("rst_nb_data",  32'(nb_ps2_data), 32'd1);
    check("rst_nb_ready", 32'(nb_if.cmd_ready), 32'd1);
    check("rst_nb_busy",  32'(nb_busy), 32'd0);
    check("rst_nb_done",  32'(nb_done), 32'd0);
    check("rst_br_clk",   32'(br_ps2_clk), 32'd1);
    check("rst_br_data",  32'(br_ps2_data), 32'd1);
    check("rst_br_ready", 32'(br_if.cmd_ready), 32'd1);
    check("rst_br_busy",  32'(br_busy), 32'd0);
    reset = 1'b0;

    // Idle for 100 cycles: nothing moves
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (!nb_ps2_clk || !nb_ps2_data || !nb_if.cmd_ready || nb_done || nb_busy) viol++;
      if (!br_ps2_clk || !br_ps2_data || !br_if.cmd_ready || br_done || br_busy) viol++;
    end
    check("idle_100", 32'(viol), 32'd0);

    // Acceptance to first data fall
    use_br = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 3'd0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 2'b10, 3'd0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!m_data) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'd2);
    check("busy_in_frame", 32'(m_busy), 32'd1);
    wait_done(3000);
    check("latency_cmd_bytes", 32'(n_got), 32'd1);

    // Table of commands
    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].br, vecs[v].sel, vecs[v].val);
      check($sformatf("v%0d_timeout", v), 32'(timed_out), 32'd0);
      check($sformatf("v%0d_nbytes", v), 32'(n_got), 32'(vecs[v].n));
      check($sformatf("v%0d_ndone", v), 32'(n_done), 32'(vecs[v].n));
      check($sformatf("v%0d_frame_err", v), 32'(n_ferr), 32'd0);
      for (int i = 0; i < vecs[v].n; i++)
        check($sformatf("v%0d_byte%0d", v, i), 32'(got_b[i]), 32'(vecs[v].bytes[71-8*i -: 8]));
      if (v == 0) begin
        for (int i = 0; i < 11; i++)
          check($sformatf("frame5a_bit%0d", i), 32'(frame_b[0][i]), 32'(exp_5a[i]));
        check("parity_25", 32'(frame_b[1][9]), 32'd0);
        check("parity_24", 32'(frame_b[2][9]), 32'd1);
        check("byte_period", 32'(done_t[1] - done_t[0]), 32'd97);
      end
    end

    // Reserved selector held valid for 50 cycles, then exit
    use_br = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 3'd7);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!m_ready || !m_clk || !m_data || m_busy || m_done) viol++;
    end
    check("reserved_ignored", 32'(viol), 32'd0);
    drive(1'b0, 1'b0, 2'b11, 3'd7);
    run_cmd(1'b0, 2'b10, 3'd0);
    check("exit_after_rsv_n", 32'(n_got), 32'd1);
    check("exit_after_rsv_b", 32'(got_b[0]), 32'h24);

    // cmd_valid held across IDLE re-entry; inputs changed after capture
    use_br = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 3'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 3'd7);
    rc = 0; dn = 0; hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (m_done) dn++;
      if (m_ready) rc++;
      else if (rc > 0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'b00, 3'd7);
    check("held_reaccept", 32'(hit), 32'd1);
    check("held_ready_cycles", 32'(rc), 32'd1);
    check("held_first_ndone", 32'(dn), 32'd1);
    wait_done(3000);
    check("held_second_n", 32'(n_got), 32'd3);
    check("held_second_b1", 32'(got_b[1]), 32'h3E);

    // Reset during bit 5 of the second byte
    use_br = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 3'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 3'd3);
    dn = 0; falls = 0; pc = 1'b1; hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (m_done) dn++;
      if (pc && !m_clk && dn == 1) falls++;
      pc = m_clk;
      if (falls == 6) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_reached", 32'(hit), 32'd1);
    check("rst_mid_pre_data", 32'(m_data), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_clk", 32'(m_clk), 32'd1);
    check("rst_mid_data", 32'(m_data), 32'd1);
    check("rst_mid_ready", 32'(m_ready), 32'd1);
    check("rst_mid_busy", 32'(m_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (!m_ready || !m_clk || !m_data || m_done) viol++;
    end
    check("rst_no_resume", 32'(viol), 32'd0);
    run_cmd(1'b0, 2'b01, 3'd0);
    check("rst_fresh_n", 32'(n_got), 32'd3);
    check("rst_fresh_b0", 32'(got_b[0]), 32'h5A);
    check("rst_fresh_b1", 32'(got_b[1]), 32'h31);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
